// File: rtl/load_store_unit_if.sv
// Purpose: core/memory bus bundle for load_store_unit.
// Signals: core request (req, we, op_size, ld_signed, addr, wdata), core
// response (busy, done, err, rdata) and data-memory access (mem_read,
// mem_write, mem_addr, mem_wdata, mem_rdata).
// Modports: slave = load_store_unit view, master = core + memory view.
interface load_store_unit_if #(
    parameter int unsigned LENGTH = 256
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned BW = AW + 2;

    logic          req;
    logic          we;
    logic [1:0]    op_size;
    logic          ld_signed;
    logic [BW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, op_size, ld_signed, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req, we, op_size, ld_signed, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: single-request load/store unit in front of a word-addressed data
// memory (combinational read, synchronous write). Adds byte/halfword access
// by read-modify-write and sign/zero extension of sub-word loads.
// Ports: clk, rst (async, active high), bus (load_store_unit_if.slave):
//   core side   req/we/op_size/ld_signed/addr/wdata -> busy/done/err/rdata
//   memory side mem_read/mem_write/mem_addr/mem_wdata, mem_rdata in
module load_store_unit #(
    parameter int unsigned LENGTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned BW = AW + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [BW-1:0] r_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          r_busy;
    logic          r_done;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          w_misaligned;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal.
    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return |lane;
            default: return 1'b1;
        endcase
    endfunction

    // Select the addressed lane(s) of a memory word and extend to 32 bits.
    function automatic logic [DW-1:0] f_extend(input logic [DW-1:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed lane(s) of the old memory word with store data.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
        logic [DW-1:0] res;
        res = old;
        case (sz)
            2'b00: res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign w_misaligned = f_misaligned(bus.op_size, bus.addr[1:0]);

    // FSM with registered Moore outputs; outputs are set on the edge that
    // enters the state they belong to. r_mem_wdata doubles as the store-data
    // latch and receives the merged word on the READ edge, so no separate
    // read buffer is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we        <= bus.we;
                        r_size      <= bus.op_size;
                        r_signed    <= bus.ld_signed;
                        r_addr      <= bus.addr;
                        r_mem_wdata <= bus.wdata;
                        r_busy      <= 1'b1;
                        if (w_misaligned) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.we && bus.op_size == 2'b10) begin
                            r_state     <= S_WRITE;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= S_READ;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_mem_read <= 1'b0;
                    if (r_we) begin
                        r_mem_wdata <= f_merge(bus.mem_rdata, r_mem_wdata, r_size, r_addr[1:0]);
                        r_state     <= S_WRITE;
                        r_mem_write <= 1'b1;
                    end else begin
                        r_rdata <= f_extend(bus.mem_rdata, r_size, r_addr[1:0], r_signed);
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_mem_write <= 1'b0;
                    r_state     <= S_DONE;
                    r_done      <= 1'b1;
                    r_err       <= 1'b0;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_addr[BW-1:2];
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: turns single core load/store requests into mem_read/mem_write word accesses on the data memory.
- Memory is word-addressed, combinational read, synchronous write; this block adds byte/halfword access via read-modify-write and sign/zero extension.
- Sits between the execute stage and the data memory, and stalls the core through busy.

Parameters:
- size, 32, data word width in bits; fixed at 32 (four little-endian byte lanes).
- length, 256, number of memory words; word address width AW = $clog2(length); byte address width BW = AW+2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- op_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned).
- ld_signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- addr  in  BW  byte address.
- wdata  in  size  store data; low bits are used for sub-word stores.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned/reserved flag; valid while done is high and held until the next completion.
- rdata  out  size  extended load result; updated only on a successful load completion, otherwise held.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  AW  word address, equal to the latched addr[BW-1:2].
- mem_wdata  out  size  merged write word.
- mem_rdata  in  size  combinational read data from memory.

Behaviour:
- Reset (asynchronous, immediate): state is IDLE; busy, done, err, mem_read and mem_write are 0; rdata, mem_addr and mem_wdata are 0. Internal latches for we, op_size, ld_signed, addr and wdata are cleared.
- States: IDLE, READ, WRITE, DONE. All memory strobes, busy and done are Moore outputs decoded from the state register.
- IDLE: when req=1, latch we, op_size, ld_signed, addr and wdata, then:
  - misaligned (half with addr[0]=1; word with addr[1:0]≠0; op_size=11) -> DONE with err set, and no memory strobe is ever asserted;
  - word store -> WRITE;
  - all loads and sub-word stores -> READ.
- IDLE with req=0: stay in IDLE.
- READ: mem_read=1. At the clock edge, capture mem_rdata into rbuf.
  - Load -> DONE. rdata is loaded with the selected lane(s), sign- or zero-extended (byte lane = addr[1:0]; half lane = addr[1]).
  - Sub-word store -> WRITE.
- WRITE: mem_write=1. mem_wdata is one of:
  - word store: the latched wdata;
  - byte store: rbuf with lane addr[1:0] replaced by wdata[7:0];
  - half store: rbuf with lane addr[1] replaced by wdata[15:0].
  - Next state is DONE.
- DONE: done=1 and busy=1; unconditionally -> IDLE. err is cleared on every non-error completion.
- Latency in cycles from the accepting edge to done high: word store 2, load 2, sub-word store 3, misaligned 1.
- mem_read and mem_write are never high in the same cycle.
- req while busy is ignored, not queued. The earliest next acceptance is the first IDLE cycle, so back-to-back requests are spaced by the operation length plus 1.
- Reset mid-operation aborts the access. No write occurs unless the WRITE-cycle edge has already passed. rdata returns to 0.
- Input changes after acceptance have no effect, because all inputs are latched.

Test Plan:
- Reset while in WRITE (asserted before the edge) -> mem_write drops immediately, memory word is unchanged, state is IDLE, busy=0, and all outputs are 0.
- Word store addr=0x010, wdata=0xDEADBEEF -> mem_write for exactly one cycle at mem_addr=4 with mem_wdata=0xDEADBEEF; done 2 cycles after accept; err=0.
- Memory word 4 = 0x11223344; byte store addr=0x012, wdata=0xAB -> one mem_read cycle, then one mem_write cycle with mem_wdata=0x11AB3344; done 3 cycles after accept.
- Word 4 = 0x80FF7F01:
  - signed byte load addr=0x012 -> rdata=0xFFFFFFFF;
  - unsigned byte load -> rdata=0x000000FF;
  - signed half load addr=0x012 -> rdata=0xFFFF80FF;
  - byte load addr=0x010 -> rdata=0x00000001.
- Misaligned half load addr=0x011 and word store addr=0x013 -> done with err=1 one cycle after accept, no mem_read/mem_write, and rdata keeps its previous value.
- req held high continuously across two word stores -> second acceptance only after DONE returns to IDLE; pulses on req during busy are ignored.
